// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD frame-refresh path: FSM encoding, screen
// geometry, command addresses, ASCII codes and the per-frame snapshot payload.
package lcd_pkg;

    localparam int unsigned NOTE_W = 3;
    localparam int unsigned POS_W  = 4;
    localparam int unsigned COL_W  = 4;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 7;

    localparam int unsigned LINE_LEN = 16;

    localparam logic [ADDR_W-1:0] LINE0_ADDR = 7'h00;
    localparam logic [ADDR_W-1:0] LINE1_ADDR = 7'h40;
    localparam logic [COL_W-1:0]  CENTRE_COL = 4'd8;
    localparam logic [COL_W-1:0]  COL_LAST   = COL_W'(LINE_LEN - 1);
    localparam logic [NOTE_W-1:0] NOTE_NONE  = 3'd7;
    localparam logic [NOTE_W-1:0] NOTE_LAST  = 3'd5;

    localparam logic [DATA_W-1:0] ASC_SPACE = 8'h20;
    localparam logic [DATA_W-1:0] ASC_STAR  = 8'h2A;
    localparam logic [DATA_W-1:0] ASC_DASH  = 8'h2D;
    localparam logic [DATA_W-1:0] ASC_COLON = 8'h3A;
    localparam logic [DATA_W-1:0] ASC_BAR   = 8'h7C;
    localparam logic [DATA_W-1:0] ASC_2     = 8'h32;
    localparam logic [DATA_W-1:0] ASC_3     = 8'h33;
    localparam logic [DATA_W-1:0] ASC_4     = 8'h34;
    localparam logic [DATA_W-1:0] ASC_A     = 8'h41;
    localparam logic [DATA_W-1:0] ASC_B     = 8'h42;
    localparam logic [DATA_W-1:0] ASC_D     = 8'h44;
    localparam logic [DATA_W-1:0] ASC_E     = 8'h45;
    localparam logic [DATA_W-1:0] ASC_G     = 8'h47;
    localparam logic [DATA_W-1:0] ASC_N     = 8'h4E;
    localparam logic [DATA_W-1:0] ASC_O     = 8'h4F;
    localparam logic [DATA_W-1:0] ASC_T     = 8'h54;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_CHAR = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    // Inputs captured at frame start; the whole frame is painted from this.
    typedef struct packed {
        logic [NOTE_W-1:0] note;
        logic [POS_W-1:0]  pos;
    } snap_t;

    // Indices 6 and 7 both mean "no signal".
    function automatic logic [NOTE_W-1:0] norm_note(input logic [NOTE_W-1:0] n);
        return (n > NOTE_LAST) ? NOTE_NONE : n;
    endfunction

endpackage

// File: rtl/lcd_screen_writer_if.sv
// Handshake bundle between the screen writer and the LCD transaction layer.
//   do_write_data / data_to_write           : level request + character
//   do_set_dd_ram_addr / dd_ram_addr        : level request + address
//   send_data_done / set_dd_ram_addr_done   : one-cycle completion pulses
interface lcd_screen_writer_if
    import lcd_pkg::*;
();
    logic              do_write_data;
    logic [DATA_W-1:0] data_to_write;
    logic              do_set_dd_ram_addr;
    logic [ADDR_W-1:0] dd_ram_addr;
    logic              send_data_done;
    logic              set_dd_ram_addr_done;

    modport master (
        output do_write_data, data_to_write, do_set_dd_ram_addr, dd_ram_addr,
        input  send_data_done, set_dd_ram_addr_done
    );

    modport slave (
        input  do_write_data, data_to_write, do_set_dd_ram_addr, dd_ram_addr,
        output send_data_done, set_dd_ram_addr_done
    );
endinterface

// File: rtl/lcd_char_rom.sv
// Combinational screen content: (line, col, note, pos) -> ASCII character.
//   line : 0 = "NOTE: xx" line, 1 = tuning indicator line
//   col  : column 0..15
//   note : normalised note index (0..5, or NOTE_NONE)
//   pos  : indicator column
//   ch_c : character to display
module lcd_char_rom
    import lcd_pkg::*;
(
    input  logic              line,
    input  logic [COL_W-1:0]  col,
    input  logic [NOTE_W-1:0] note,
    input  logic [POS_W-1:0]  pos,
    output logic [DATA_W-1:0] ch_c
);
    logic [DATA_W-1:0] letter;
    logic [DATA_W-1:0] digit;
    logic              has_note;

    // Note name pair; dashes when there is no signal.
    always_comb begin
        letter = ASC_DASH;
        digit  = ASC_DASH;
        case (note)
            3'd0:    begin letter = ASC_E; digit = ASC_2; end
            3'd1:    begin letter = ASC_A; digit = ASC_2; end
            3'd2:    begin letter = ASC_D; digit = ASC_3; end
            3'd3:    begin letter = ASC_G; digit = ASC_3; end
            3'd4:    begin letter = ASC_B; digit = ASC_3; end
            3'd5:    begin letter = ASC_E; digit = ASC_4; end
            default: begin letter = ASC_DASH; digit = ASC_DASH; end
        endcase
    end

    assign has_note = (note <= NOTE_LAST);

    always_comb begin
        ch_c = ASC_SPACE;
        if (!line) begin
            case (col)
                4'd0:    ch_c = ASC_N;
                4'd1:    ch_c = ASC_O;
                4'd2:    ch_c = ASC_T;
                4'd3:    ch_c = ASC_E;
                4'd4:    ch_c = ASC_COLON;
                4'd6:    ch_c = letter;
                4'd7:    ch_c = digit;
                default: ch_c = ASC_SPACE;
            endcase
        end else if (has_note) begin
            if (col == pos)             ch_c = ASC_STAR;
            else if (col == CENTRE_COL) ch_c = ASC_BAR;
            else                        ch_c = ASC_DASH;
        end
    end
endmodule

// File: rtl/lcd_screen_writer.sv
// Frame-refresh controller: on update_req snapshots note/position and paints
// both LCD lines (address command + 16 character writes each) through the
// transaction layer's level-request / done-pulse handshake.
//   clk, reset_n          : clock, async active-low reset
//   update_req            : one-cycle refresh request
//   note_idx, tune_pos    : display inputs, sampled at frame start
//   bus (master)          : transaction-layer handshake
//   busy                  : frame in progress
//   frame_done            : one-cycle pulse after the last character
module lcd_screen_writer
    import lcd_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               update_req,
    input  logic [NOTE_W-1:0]  note_idx,
    input  logic [POS_W-1:0]   tune_pos,
    lcd_screen_writer_if.master bus,
    output logic               busy,
    output logic               frame_done
);
    state_t            state, state_n;
    state_t            gap_tgt, gap_tgt_n;
    logic              line, line_n;
    logic [COL_W-1:0]  col, col_n;
    snap_t             snap, snap_n;
    logic              pending, pending_n;
    logic              busy_n, frame_done_n;
    logic              start;

    logic              do_w_n, do_a_n;
    logic [DATA_W-1:0] data_n;
    logic [ADDR_W-1:0] addr_n;
    logic [DATA_W-1:0] rom_c;

    lcd_char_rom u_rom (
        .line (line_n),
        .col  (col_n),
        .note (snap_n.note),
        .pos  (snap_n.pos),
        .ch_c (rom_c)
    );

    // State, counters, snapshot and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state                  <= S_IDLE;
            gap_tgt                <= S_CHAR;
            line                   <= 1'b0;
            col                    <= '0;
            snap                   <= '0;
            pending                <= 1'b0;
            busy                   <= 1'b0;
            frame_done             <= 1'b0;
            bus.do_write_data      <= 1'b0;
            bus.data_to_write      <= '0;
            bus.do_set_dd_ram_addr <= 1'b0;
            bus.dd_ram_addr        <= '0;
        end else begin
            state                  <= state_n;
            gap_tgt                <= gap_tgt_n;
            line                   <= line_n;
            col                    <= col_n;
            snap                   <= snap_n;
            pending                <= pending_n;
            busy                   <= busy_n;
            frame_done             <= frame_done_n;
            bus.do_write_data      <= do_w_n;
            bus.data_to_write      <= data_n;
            bus.do_set_dd_ram_addr <= do_a_n;
            bus.dd_ram_addr        <= addr_n;
        end
    end

    // Next-state logic. S_GAP with gap_tgt == S_IDLE is a back-to-back restart.
    always_comb begin
        state_n      = state;
        gap_tgt_n    = gap_tgt;
        line_n       = line;
        col_n        = col;
        snap_n       = snap;
        pending_n    = pending;
        busy_n       = busy;
        frame_done_n = 1'b0;
        start        = 1'b0;

        case (state)
            S_IDLE: begin
                if (update_req || pending) start = 1'b1;
            end
            S_ADDR: begin
                if (bus.set_dd_ram_addr_done) begin
                    state_n   = S_GAP;
                    gap_tgt_n = S_CHAR;
                end
            end
            S_CHAR: begin
                if (bus.send_data_done) begin
                    state_n = S_GAP;
                    if (col != COL_LAST) begin
                        col_n     = col + COL_W'(1);
                        gap_tgt_n = S_CHAR;
                    end else if (!line) begin
                        line_n    = 1'b1;
                        col_n     = '0;
                        gap_tgt_n = S_ADDR;
                    end else begin
                        frame_done_n = 1'b1;
                        if (pending || update_req) begin
                            gap_tgt_n = S_IDLE;
                        end else begin
                            state_n = S_IDLE;
                            busy_n  = 1'b0;
                        end
                    end
                end
            end
            S_GAP: begin
                if (gap_tgt == S_IDLE) start = 1'b1;
                else                   state_n = gap_tgt;
            end
            default: state_n = S_IDLE;
        endcase

        // Requests during a frame collapse into one pending refresh.
        if (state != S_IDLE && update_req) pending_n = 1'b1;

        if (start) begin
            snap_n.note = norm_note(note_idx);
            snap_n.pos  = tune_pos;
            pending_n   = 1'b0;
            line_n      = 1'b0;
            col_n       = '0;
            state_n     = S_ADDR;
            busy_n      = 1'b1;
        end
    end

    // Request/payload next values; payload holds while the request is low.
    always_comb begin
        do_a_n = (state_n == S_ADDR);
        do_w_n = (state_n == S_CHAR);
        addr_n = bus.dd_ram_addr;
        data_n = bus.data_to_write;
        if (do_a_n) addr_n = line_n ? LINE1_ADDR : LINE0_ADDR;
        if (do_w_n) data_n = rom_c;
    end
endmodule

// File: tb/tb_lcd_screen_writer.sv
// Bench for lcd_screen_writer: transaction-layer model with fixed done
// latency, scoreboard of expected commands per frame, handshake checks.
module tb_lcd_screen_writer;
    import lcd_pkg::*;

    localparam int LAT = 20;

    typedef struct {
        bit         is_addr;
        logic [7:0] val;
    } cmd_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       update_req = 1'b0;
    logic [2:0] note_idx = '0;
    logic [3:0] tune_pos = '0;
    logic       busy;
    logic       frame_done;

    lcd_screen_writer_if bus ();

    lcd_screen_writer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .update_req (update_req),
        .note_idx   (note_idx),
        .tune_pos   (tune_pos),
        .bus        (bus),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_err = 0;
    int   n_acc = 0;
    int   n_fd  = 0;
    bit   spur  = 1'b0;
    cmd_t exp_q[$];

    bit         m_busy = 1'b0;
    bit         m_gap  = 1'b0;
    bit         m_is_addr = 1'b0;
    logic [7:0] m_val = '0;
    int         m_cnt = 0;
    int         idle_tick = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected command stream for one frame, built from display strings.
    task automatic push_frame(input int note, input int pos);
        string names[6];
        string l0;
        cmd_t  c;
        byte   ch;
        names = '{"E2", "A2", "D3", "G3", "B3", "E4"};
        l0 = "NOTE: ";
        if (note < 6) l0 = {l0, names[note]};
        else          l0 = {l0, "--"};
        l0 = {l0, "        "};
        c.is_addr = 1'b1; c.val = 8'h00; exp_q.push_back(c);
        for (int i = 0; i < 16; i++) begin
            c.is_addr = 1'b0; c.val = l0[i]; exp_q.push_back(c);
        end
        c.is_addr = 1'b1; c.val = 8'h40; exp_q.push_back(c);
        for (int i = 0; i < 16; i++) begin
            if (note >= 6)     ch = " ";
            else if (i == pos) ch = "*";
            else if (i == 8)   ch = "|";
            else               ch = "-";
            c.is_addr = 1'b0; c.val = ch; exp_q.push_back(c);
        end
    endtask

    // Transaction-layer model, evaluated on the falling edge.
    always @(negedge clk) begin
        cmd_t e;
        if (!reset_n) begin
            m_busy = 1'b0;
            m_gap  = 1'b0;
            bus.send_data_done       = 1'b0;
            bus.set_dd_ram_addr_done = 1'b0;
        end else begin
            bus.send_data_done       = 1'b0;
            bus.set_dd_ram_addr_done = 1'b0;
            chk("both_req", 32'(bus.do_write_data & bus.do_set_dd_ram_addr), 0);
            if (m_gap) begin
                chk("gap_after_done", 32'(bus.do_write_data | bus.do_set_dd_ram_addr), 0);
                m_gap = 1'b0;
            end else if (m_busy) begin
                if (m_is_addr) begin
                    chk("addr_req_held", 32'(bus.do_set_dd_ram_addr), 1);
                    chk("addr_stable", 32'(bus.dd_ram_addr), 32'(m_val));
                end else begin
                    chk("data_req_held", 32'(bus.do_write_data), 1);
                    chk("data_stable", 32'(bus.data_to_write), 32'(m_val));
                end
                m_cnt--;
                if (spur && m_is_addr && m_cnt > 0 && (m_cnt % 4) == 0)
                    bus.send_data_done = 1'b1;
                if (m_cnt == 0) begin
                    if (m_is_addr) bus.set_dd_ram_addr_done = 1'b1;
                    else           bus.send_data_done       = 1'b1;
                    m_busy = 1'b0;
                    m_gap  = 1'b1;
                end
            end else if (bus.do_write_data || bus.do_set_dd_ram_addr) begin
                m_is_addr = bus.do_set_dd_ram_addr;
                m_val  = m_is_addr ? {1'b0, bus.dd_ram_addr} : bus.data_to_write;
                m_busy = 1'b1;
                m_cnt  = LAT;
                n_acc++;
                chk("cmd_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("cmd_kind", 32'(m_is_addr), 32'(e.is_addr));
                    chk("cmd_val", 32'(m_val), 32'(e.val));
                end
            end else if (spur) begin
                // Init-phase style done pulses while nothing is outstanding.
                idle_tick++;
                if (idle_tick % 2 == 0) bus.send_data_done = 1'b1;
            end
        end
    end

    always @(negedge clk) if (frame_done === 1'b1) n_fd++;

    task automatic pulse_update();
        @(negedge clk); update_req = 1'b1;
        @(negedge clk); update_req = 1'b0;
    endtask

    task automatic wait_frame_end();
        int t = 0;
        while ((busy !== 1'b0 || exp_q.size() != 0 || m_busy) && t < 4000) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        chk("end_busy", 32'(busy), 0);
        chk("queue_drained", 32'(exp_q.size()), 0);
    endtask

    initial begin
        int fd0;
        int base;
        int t;

        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_do_write", 32'(bus.do_write_data), 0);
        chk("rst_do_addr", 32'(bus.do_set_dd_ram_addr), 0);
        chk("rst_data", 32'(bus.data_to_write), 0);
        chk("rst_addr", 32'(bus.dd_ram_addr), 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Spurious done pulses with nothing outstanding must not start anything.
        spur = 1'b1;
        repeat (10) @(negedge clk);
        spur = 1'b0;
        chk("idle_spur_busy", 32'(busy), 0);
        chk("idle_spur_req", 32'(bus.do_write_data | bus.do_set_dd_ram_addr), 0);

        // Frame 1: A2, in tune.
        note_idx = 3'd1; tune_pos = 4'd8;
        push_frame(1, 8);
        pulse_update();
        wait_frame_end();
        chk("fd_count_1", 32'(n_fd), 1);

        // No signal, including index 6 aliasing to 7.
        note_idx = 3'd7; tune_pos = 4'd3;
        push_frame(7, 3);
        pulse_update();
        wait_frame_end();
        chk("fd_count_2", 32'(n_fd), 2);

        note_idx = 3'd6; tune_pos = 4'd0;
        push_frame(7, 0);
        pulse_update();
        wait_frame_end();
        chk("fd_count_3", 32'(n_fd), 3);

        // Several requests mid-frame collapse into one follow-up frame.
        note_idx = 3'd1; tune_pos = 4'd8;
        push_frame(1, 8);
        pulse_update();
        repeat (150) @(negedge clk);
        note_idx = 3'd4; tune_pos = 4'd15;
        push_frame(4, 15);
        pulse_update();
        repeat (40) @(negedge clk);
        pulse_update();
        repeat (40) @(negedge clk);
        pulse_update();
        wait_frame_end();
        chk("fd_count_pending", 32'(n_fd), 5);

        // Spurious send_data_done while address commands are outstanding.
        spur = 1'b1;
        note_idx = 3'd0; tune_pos = 4'd0;
        push_frame(0, 0);
        pulse_update();
        wait_frame_end();
        spur = 1'b0;
        chk("fd_count_spur", 32'(n_fd), 6);

        // Reset while line 1 column 5 is outstanding.
        note_idx = 3'd5; tune_pos = 4'd2;
        push_frame(5, 2);
        base = n_acc;
        pulse_update();
        t = 0;
        while (n_acc < base + 24 && t < 2000) begin
            @(posedge clk);
            t++;
        end
        chk("reached_l1_c5", 32'(n_acc - base), 24);
        fd0 = n_fd;
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_do_write", 32'(bus.do_write_data), 0);
        chk("mid_rst_do_addr", 32'(bus.do_set_dd_ram_addr), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        repeat (3) @(negedge clk);
        chk("mid_rst_no_fd", 32'(n_fd), 32'(fd0));
        exp_q.delete();
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst_no_fd", 32'(n_fd), 32'(fd0));

        note_idx = 3'd3; tune_pos = 4'd8;
        push_frame(3, 8);
        pulse_update();
        wait_frame_end();
        chk("fd_count_repaint", 32'(n_fd), 32'(fd0 + 1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/lcd_screen_writer.md
# lcd_screen_writer

Frame-refresh controller sitting directly upstream of the LCD transaction layer in the guitar tuner display path. On each update request it snapshots the detected string and tuning-indicator position, then paints a full 2x16 screen. Each line is one Set DD RAM Address command followed by 16 Write Data commands, issued over the transaction layer's level-held request / done-pulse handshake.

## Interface
- No parameters. Line addresses are 0x00 and 0x40, line length is 16, and the indicator centre is column 8; all fixed in the package.
- `clk` in 1: system clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `update_req` in 1: one-cycle pulse requesting a screen refresh.
- `note_idx` in 3: string index. 0..5 = E2 A2 D3 G3 B3 E4; 7 = no signal; 6 is treated as 7.
- `tune_pos` in 4: indicator column 0..15; 8 = in tune.
- `do_write_data` out 1: level request, write one character.
- `data_to_write` out 8: ASCII character; stable while the request is high.
- `do_set_dd_ram_addr` out 1: level request, set the DD RAM address.
- `dd_ram_addr` out 7: address; stable while the request is high.
- `send_data_done` in 1: completion pulse from the transaction layer. It also pulses during the layer's own init commands.
- `set_dd_ram_addr_done` in 1: completion pulse for an address command.
- `busy` out 1: high from frame start until frame end.
- `frame_done` out 1: one-cycle pulse after the last character of line 1.

## Operation
- States: S_IDLE, S_ADDR, S_CHAR, S_GAP. Registers: line (1b), col (4b), snapshot {note, pos}, pending (1b).
- S_IDLE, on `update_req` (or pending set):
  - Snapshot the inputs, clear pending, set line=0 and col=0.
  - Go to S_ADDR, set `busy`.
- S_ADDR:
  - Drive `do_set_dd_ram_addr`=1 with `dd_ram_addr` = line ? 0x40 : 0x00.
  - On `set_dd_ram_addr_done`: drop the request, go to S_GAP, next S_CHAR.
- S_CHAR:
  - Drive `do_write_data`=1 with `data_to_write` = char(line, col, snapshot).
  - Ignore `send_data_done` in every state other than S_CHAR.
  - On `send_data_done`, drop the request and:
    - col<15: col++, S_GAP, next S_CHAR.
    - col==15 and line==0: line=1, col=0, S_GAP, next S_ADDR.
    - col==15 and line==1: pulse `frame_done`. If pending, restart through S_GAP to the snapshot step; otherwise go to S_IDLE and clear `busy`.
- S_GAP: all requests low for exactly one cycle. This guarantees the transaction layer sees a low request in its IDLE state, so a held request never causes a double issue.
- Line 0 characters (col 0..15): "NOTE: " + letter + digit, then 8 spaces.
  - Letter/digit per note_idx: E2 A2 D3 G3 B3 E4.
  - No signal: "--".
- Line 1 characters:
  - col==pos → '*'.
  - otherwise col==8 → '|'.
  - otherwise '-'.
  - No signal: 16 spaces.
- `update_req` while `busy` sets pending; multiple requests collapse into one. The current frame finishes with its own snapshot. The next frame snapshots the inputs at its start.
- `update_req` in the same cycle as the final done: this counts as pending, and a new frame follows.
- The first command of every frame is an address command. Init-phase `send_data_done` pulses therefore can never complete a character write.

## Timing
- Reset values: all outputs 0, state S_IDLE, pending 0.
- Reset mid-frame: immediate return to S_IDLE with all requests dropped. No `frame_done`.
- All outputs are registered.
- A request rises 1 cycle after the state entry decision: `update_req` at edge n gives `do_set_dd_ram_addr` high from cycle n+1.
- A done pulse sampled at edge t clears the request on that same edge. The next request rises at t+2 (the S_GAP cycle sits between).
- Per frame: 2 address commands and 32 character writes.
- Cycles per frame: 34 × (transaction latency + 2).

## Structure
- Package `lcd_pkg`:
  - state encoding,
  - LINE0_ADDR=7'h00, LINE1_ADDR=7'h40,
  - LINE_LEN=16, CENTRE_COL=8, NOTE_NONE=3'd7,
  - ASCII constants.
- Sub-module `lcd_char_rom`: purely combinational (line, col, note, pos) → 8-bit ASCII. It is unit-testable on its own.
- The FSM and counters live in `lcd_screen_writer`.

## Test plan
- Reset, then `update_req` with note=1, pos=8, using a transaction-layer model with 20-cycle done latency.
  - Required: addr 0x00, then "NOTE: A2" plus 8 spaces.
  - Then addr 0x40, then "--------*-------".
  - Exactly one `frame_done`, and `busy` low afterwards.
- note=7, pos=3.
  - Required: line 0 "NOTE: --" plus spaces; line 1 16 spaces.
- Three `update_req` pulses during a frame, with inputs changed to note=4, pos=15.
  - Required: exactly one extra frame, and it shows "NOTE: B3" and '*' at col 15 with '|' at col 8.
- Model emits spurious `send_data_done` pulses while the writer sits in S_ADDR (init phase).
  - Required: col does not advance; the address request is held until `set_dd_ram_addr_done`.
- `reset_n` low during line 1, col 5.
  - Required: requests low in the same cycle, no `frame_done`.
  - A later update repaints from addr 0x00.
- Check every handshake for three properties:
  - requests never both high;
  - data and address stable while a request is high;
  - a request is low for ≥1 cycle after each done.
